id_ex_ctrl_stage: RTL and testbench
===================================

ID_EX_CTRL_STAGE -- requirements
Module: id_ex_ctrl_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports branch_d, mem_write_d, mem_to_reg_d, alu_src_d, reg_write_d, jump_d, uilu_d, load_d  input  1 each  decode-stage control bits.
REQ-006 SHALL have port alu_op_d  input  2  decode-stage ALU op class.
REQ-007 SHALL have ports rs1_d, rs2_d, rd_d  input  5 each  decode-stage register indices.
REQ-008 SHALL have port valid_d  input  1  decode stage holds a real instruction.
REQ-009 SHALL have port flush  input  1  taken branch/jump resolved in EX; kill decode-stage instruction.
REQ-010 SHALL have ports branch_e, mem_write_e, mem_to_reg_e, alu_src_e, reg_write_e, jump_e, uilu_e, load_e, alu_op_e, rs1_e, rs2_e, rd_e  output  widths as *_d  registered EX-stage copies.
REQ-011 SHALL have port valid_e  output  1  EX stage holds a real instruction.
REQ-012 SHALL have port stall  output  1  load-use hazard; drives decoder Stall input, PC and IF/ID hold.
REQ-013 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  performance counters (see Configuration).

Function
REQ-014 SHALL compute stall combinationally: valid_e & load_e & (rd_e != 0) & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d)) & !flush.
REQ-015 SHALL, on each rising clk with neither flush nor stall, load every *_e from its *_d and valid_e from valid_d (latency 1 cycle).
REQ-016 SHALL, on a rising clk with stall=1, load a bubble: all control outputs 0, alu_op_e=00, valid_e=0, indices 0.
REQ-017 SHALL, on a rising clk with flush=1, load a bubble regardless of stall or valid_d; flush has priority.
REQ-018 SHALL produce a stall of exactly one cycle per load-use pair, since the inserted bubble clears load_e.
REQ-019 SHALL load a bubble whenever valid_d=0, independent of the *_d control values.
REQ-020 SHALL register mem_to_reg_d as 0 when it is X-free-required: any X on mem_to_reg_d with reg_write_d=0 SHALL be captured as 0.
REQ-021 SHALL never assert stall on rd_e=0 (x0 writes are discarded).

Reset
REQ-022 SHALL, while reset=1, hold all *_e outputs and valid_e at 0, and stall at 0.
REQ-023 SHALL clear stall_cnt and flush_cnt to 0 on reset; reset mid-stall drops stall in the same cycle.
REQ-024 SHALL resume normal capture on the first rising clk after reset deasserts.

Configuration
REQ-025 SHALL compile the counters only when macro HAZARD_PERF_CNT_EN is defined.
REQ-026 SHALL, with HAZARD_PERF_CNT_EN, increment stall_cnt on each clk where stall=1 and flush_cnt on each clk where flush=1, both saturating at 2^CNT_W-1.
REQ-027 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cnt and flush_cnt to constant 0 with no counter flops.

Verification
REQ-028 SHALL cover passthrough: valid_d=1, reg_write_d=1, alu_op_d=10, rd_d=5 -> next cycle reg_write_e=1, alu_op_e=10, rd_e=5, valid_e=1, stall=0.
REQ-029 SHALL cover load-use: EX holds load rd_e=7; ID rs2_d=7 -> stall=1 one cycle, next EX bubble (valid_e=0), stall_cnt=1.
REQ-030 SHALL cover x0: EX load rd_e=0, ID rs1_d=0 -> stall=0, instruction passes next cycle.
REQ-031 SHALL cover flush over stall: load-use condition plus flush=1 -> stall=0, bubble captured, flush_cnt=1.
REQ-032 SHALL cover reset mid-operation: reset asserted while valid_e=1, reg_write_e=1 -> outputs 0 immediately, counters 0.
REQ-033 SHALL cover saturation with CNT_W=4 and HAZARD_PERF_CNT_EN: 20 stall cycles -> stall_cnt=15; without macro -> stall_cnt=0.

Source files
------------

// File: rtl/id_ex_ctrl_stage.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl_stage
//   ID/EX pipeline register for the control/index fields plus the load-use
//   hazard detector. A load in EX whose destination matches a source of the
//   decode-stage instruction stalls decode for one cycle and injects a bubble
//   into EX. A flush from EX always kills the decode-stage instruction.
//
// Ports
//   clk, reset          : rising-edge clock, async active-high reset
//   *_d, valid_d        : decode-stage control bits, ALU op, reg indices
//   flush               : taken branch/jump resolved in EX, kill decode slot
//   *_e, valid_e        : registered EX-stage copies
//   stall               : load-use hazard (holds PC / IF-ID, stalls decoder)
//   stall_cnt/flush_cnt : saturating perf counters, width CNT_W
//
// Build option
//   HAZARD_PERF_CNT_EN  : when defined, the counters are built; otherwise
//                         both counter outputs are constant 0, no flops.
// ---------------------------------------------------------------------------
module id_ex_ctrl_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_d,
  input  logic             mem_write_d,
  input  logic             mem_to_reg_d,
  input  logic             alu_src_d,
  input  logic             reg_write_d,
  input  logic             jump_d,
  input  logic             uilu_d,
  input  logic             load_d,
  input  logic [1:0]       alu_op_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             valid_d,
  input  logic             flush,
  output logic             branch_e,
  output logic             mem_write_e,
  output logic             mem_to_reg_e,
  output logic             alu_src_e,
  output logic             reg_write_e,
  output logic             jump_e,
  output logic             uilu_e,
  output logic             load_e,
  output logic [1:0]       alu_op_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic             valid_e,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       uilu;
    logic       load;
    logic [1:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       valid;
  } ex_ctrl_t;

  ex_ctrl_t ex_q, ex_d;

  // Load-use hazard. rd=0 never stalls since x0 writes are dropped. Flush
  // masks it: the decode instruction is being killed anyway. Once the bubble
  // lands, load_e drops, so each load-use pair stalls exactly one cycle.
  always_comb begin
    stall = ex_q.valid & ex_q.load & (ex_q.rd != 5'd0) & valid_d &
            ((ex_q.rd == rs1_d) | (ex_q.rd == rs2_d)) & ~flush;
  end

  always_comb begin
    ex_d = '0;
    if (!flush && !stall && valid_d) begin
      ex_d.branch     = branch_d;
      ex_d.mem_write  = mem_write_d;
      // AND with reg_write so an undriven (X) mem_to_reg on non-writing
      // instructions lands as a clean 0.
      ex_d.mem_to_reg = mem_to_reg_d & reg_write_d;
      ex_d.alu_src    = alu_src_d;
      ex_d.reg_write  = reg_write_d;
      ex_d.jump       = jump_d;
      ex_d.uilu       = uilu_d;
      ex_d.load       = load_d;
      ex_d.alu_op     = alu_op_d;
      ex_d.rs1        = rs1_d;
      ex_d.rs2        = rs2_d;
      ex_d.rd         = rd_d;
      ex_d.valid      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign branch_e     = ex_q.branch;
  assign mem_write_e  = ex_q.mem_write;
  assign mem_to_reg_e = ex_q.mem_to_reg;
  assign alu_src_e    = ex_q.alu_src;
  assign reg_write_e  = ex_q.reg_write;
  assign jump_e       = ex_q.jump;
  assign uilu_e       = ex_q.uilu;
  assign load_e       = ex_q.load;
  assign alu_op_e     = ex_q.alu_op;
  assign rs1_e        = ex_q.rs1;
  assign rs2_e        = ex_q.rs2;
  assign rd_e         = ex_q.rd;
  assign valid_e      = ex_q.valid;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_ctrl_stage
//   Directed-vector bench for id_ex_ctrl_stage (CNT_W=4). Counter
//   expectations follow HAZARD_PERF_CNT_EN: counts when defined, 0 otherwise.
// ---------------------------------------------------------------------------
module tb_id_ex_ctrl_stage;
  localparam int CNT_W = 4;

  logic clk, reset;
  logic branch_d, mem_write_d, mem_to_reg_d, alu_src_d, reg_write_d;
  logic jump_d, uilu_d, load_d, valid_d, flush;
  logic [1:0] alu_op_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic branch_e, mem_write_e, mem_to_reg_e, alu_src_e, reg_write_e;
  logic jump_e, uilu_e, load_e, valid_e, stall;
  logic [1:0] alu_op_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  id_ex_ctrl_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .branch_d(branch_d), .mem_write_d(mem_write_d), .mem_to_reg_d(mem_to_reg_d),
    .alu_src_d(alu_src_d), .reg_write_d(reg_write_d), .jump_d(jump_d),
    .uilu_d(uilu_d), .load_d(load_d), .alu_op_d(alu_op_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .valid_d(valid_d), .flush(flush),
    .branch_e(branch_e), .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e),
    .alu_src_e(alu_src_e), .reg_write_e(reg_write_e), .jump_e(jump_e),
    .uilu_e(uilu_e), .load_e(load_e), .alu_op_e(alu_op_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .valid_e(valid_e),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: br mw m2r asrc rw jmp uilu ld op[2] rs1[5] rs2[5] rd[5] vld
  logic [25:0] e_vec;
  assign e_vec = {branch_e, mem_write_e, mem_to_reg_e, alu_src_e, reg_write_e,
                  jump_e, uilu_e, load_e, alu_op_e, rs1_e, rs2_e, rd_e, valid_e};

  function automatic logic [25:0] mk(input logic [7:0] ctl, input logic [1:0] op,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [4:0] d, input logic v);
    return {ctl, op, s1, s2, d, v};
  endfunction

  task automatic drv(input logic [25:0] v);
    {branch_d, mem_write_d, mem_to_reg_d, alu_src_d, reg_write_d,
     jump_d, uilu_d, load_d, alu_op_d, rs1_d, rs2_d, rd_d, valid_d} = v;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counter expectation depends on whether the counters are built.
  function automatic logic [31:0] cnt_exp(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return (n > 15) ? 32'd15 : 32'(n);
`else
    return 32'd0 + 32'(n & 0);
`endif
  endfunction

  // Control-byte constants: bit7 branch .. bit0 load
  localparam logic [7:0] C_RW   = 8'b0000_1000;
  localparam logic [7:0] C_LD   = 8'b0010_1001; // mem_to_reg, reg_write, load
  localparam logic [7:0] C_ALL  = 8'b1111_1111;

  logic [25:0] v;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drv(mk(C_ALL, 2'b11, 5'd1, 5'd2, 5'd3, 1'b1));
    step(); step();
    // Reset holds everything low even with a valid instruction in decode.
    chk("rst_vec", 32'(e_vec), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    chk("rst_fcnt", 32'(flush_cnt), 32'd0);

    // Release reset away from the edge; first edge captures.
    reset = 1'b0;
    v = mk(C_RW, 2'b10, 5'd1, 5'd2, 5'd5, 1'b1);
    drv(v);
    step();
    chk("pass_rw", 32'(reg_write_e), 32'd1);
    chk("pass_op", 32'(alu_op_e), 32'd2);
    chk("pass_rd", 32'(rd_e), 32'd5);
    chk("pass_vld", 32'(valid_e), 32'd1);
    chk("pass_stall", 32'(stall), 32'd0);

    // All fields set: everything passes straight through.
    v = mk(C_ALL & ~8'h01, 2'b01, 5'd17, 5'd30, 5'd9, 1'b1);
    drv(v);
    step();
    chk("pass_all", 32'(e_vec), 32'(v));

    // Load-use on rs2.
    drv(mk(C_LD, 2'b00, 5'd2, 5'd0, 5'd7, 1'b1));
    step();
    chk("ld_in_ex", 32'(load_e), 32'd1);
    v = mk(C_RW, 2'b10, 5'd3, 5'd7, 5'd8, 1'b1);
    drv(v);
    chk("lu_stall", 32'(stall), 32'd1);
    step();
    chk("lu_bubble", 32'(e_vec), 32'd0);
    chk("lu_stall_1cyc", 32'(stall), 32'd0);
    chk("lu_scnt", 32'(stall_cnt), cnt_exp(1));
    step();
    chk("lu_resume", 32'(e_vec), 32'(v));

    // Load-use on rs1.
    drv(mk(C_LD, 2'b00, 5'd2, 5'd0, 5'd12, 1'b1));
    step();
    drv(mk(C_RW, 2'b10, 5'd12, 5'd4, 5'd8, 1'b1));
    chk("lu_rs1_stall", 32'(stall), 32'd1);
    step();
    chk("lu_rs1_bubble", 32'(valid_e), 32'd0);
    chk("lu_rs1_scnt", 32'(stall_cnt), cnt_exp(2));

    // x0 destination never stalls.
    drv(mk(C_LD, 2'b00, 5'd2, 5'd0, 5'd0, 1'b1));
    step();
    v = mk(C_RW, 2'b10, 5'd0, 5'd6, 5'd4, 1'b1);
    drv(v);
    chk("x0_stall", 32'(stall), 32'd0);
    step();
    chk("x0_pass", 32'(e_vec), 32'(v));

    // Invalid decode slot: no stall on matching indices, bubble captured.
    drv(mk(C_LD, 2'b00, 5'd2, 5'd0, 5'd7, 1'b1));
    step();
    drv(mk(C_ALL, 2'b11, 5'd7, 5'd7, 5'd7, 1'b0));
    chk("inv_stall", 32'(stall), 32'd0);
    step();
    chk("inv_bubble", 32'(e_vec), 32'd0);

    // Flush beats a live load-use hazard.
    drv(mk(C_LD, 2'b00, 5'd2, 5'd0, 5'd9, 1'b1));
    step();
    drv(mk(C_RW, 2'b10, 5'd9, 5'd1, 5'd8, 1'b1));
    chk("pre_flush_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    step();
    flush = 1'b0;
    chk("flush_bubble", 32'(e_vec), 32'd0);
    chk("flush_fcnt", 32'(flush_cnt), cnt_exp(1));
    chk("flush_scnt", 32'(stall_cnt), cnt_exp(2));

    // X on mem_to_reg with reg_write=0 lands as 0.
    drv(mk(8'b0000_0000, 2'b00, 5'd1, 5'd1, 5'd1, 1'b1));
    mem_to_reg_d = 1'bx;
    #1;
    step();
    chk("m2r_x", 32'(mem_to_reg_e), 32'd0);
    chk("m2r_x_vld", 32'(valid_e), 32'd1);

    // Reset mid-operation with a stall pending.
    drv(mk(C_LD, 2'b00, 5'd2, 5'd0, 5'd7, 1'b1));
    step();
    drv(mk(C_RW, 2'b10, 5'd7, 5'd1, 5'd8, 1'b1));
    chk("mid_pre_stall", 32'(stall), 32'd1);
    chk("mid_pre_rw", 32'(reg_write_e), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_vec", 32'(e_vec), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_scnt", 32'(stall_cnt), 32'd0);
    chk("mid_rst_fcnt", 32'(flush_cnt), 32'd0);
    step();
    reset = 1'b0;

    // Saturation: a self-dependent load in decode stalls every other cycle.
    drv(mk(C_LD, 2'b00, 5'd7, 5'd0, 5'd7, 1'b1));
    step();
    chk("sat_stall_a", 32'(stall), 32'd1);
    step();
    chk("sat_stall_b", 32'(stall), 32'd0);
    step();
    chk("sat_stall_c", 32'(stall), 32'd1);
    for (int i = 0; i < 40; i++) step();
    chk("sat_scnt", 32'(stall_cnt), cnt_exp(20));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1);
  end
endmodule
